// File: rtl/i2s_pkg.sv
// Shared I2S transmitter definitions.
// Default slot width, derived frame geometry and FSM state type.
package i2s_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FRAME_LEN = 2 * WIDTH_DEF;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/i2s_hold_buf.sv
// One-entry valid/ready holding buffer for a {left,right} sample pair.
// Ports: clk/rst, push_valid/push_ready/push_data in, pop strobe, full/data out.
module i2s_hold_buf #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic [DW-1:0] data
);

  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;

  // Push only when empty, so a push never collides with a pop
  // of a real entry; a pop of an empty buffer is a no-op.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (push_valid && !full_q) begin
      full_d = 1'b1;
      data_d = push_data;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign push_ready = !full_q;
  assign full       = full_q;
  assign data       = data_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: serializes buffered {left,right} pairs onto lrclk/sdata.
// Ports: sclk/rst, en, s_valid/s_ready/s_left/s_right, lrclk, sdata, busy, underrun.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             en,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_left,
  input  logic [WIDTH-1:0] s_right,
  output logic             lrclk,
  output logic             sdata,
  output logic             busy,
  output logic             underrun
);

  localparam int FL = 2 * WIDTH;
  localparam int CW = $clog2(FL);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FL-1:0]   sh_q, sh_d;
  logic            lrclk_q, lrclk_d;
  logic            sdata_q, sdata_d;
  logic            underrun_q, underrun_d;

  logic            hold_full;
  logic [FL-1:0]   hold_data;
  logic            decide;
  logic            load;
  logic [FL-1:0]   frame;

  // Frame decisions happen on every edge in IDLE and on the
  // edge that ends cycle 0 while running.
  assign decide = (state_q == IDLE) || (cnt_q == '0);
  assign load   = decide && en;

  i2s_hold_buf #(
    .DW (FL)
  ) u_hold (
    .clk        (sclk),
    .rst        (rst),
    .push_valid (s_valid),
    .push_ready (s_ready),
    .push_data  ({s_left, s_right}),
    .pop        (load),
    .full       (hold_full),
    .data       (hold_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    frame      = hold_full ? hold_data : '0;
    if (decide) begin
      if (en) begin
        // MSB goes straight to the pin; the shifter keeps the rest,
        // so the right LSB lands in cycle 0 of the next frame.
        state_d    = RUN;
        cnt_d      = CW'(1);
        sdata_d    = frame[FL-1];
        sh_d       = frame << 1;
        underrun_d = !hold_full;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        sdata_d = 1'b0;
        sh_d    = '0;
      end
    end else begin
      sdata_d = sh_q[FL-1];
      sh_d    = sh_q << 1;
      cnt_d   = (cnt_q == CW'(FL - 1)) ? '0 : cnt_q + CW'(1);
    end
    lrclk_d = (cnt_d >= CW'(WIDTH));
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign busy     = (state_q == RUN);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx at WIDTH=32 and WIDTH=16.
// Expected serial stream is derived from the I2S slot rules.
module tb_i2s_tx;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic rst;

  logic        en_a, sv_a, rdy_a, lr_a, sd_a, busy_a, ur_a;
  logic [31:0] sl_a, sr_a;
  logic        en_b, sv_b, rdy_b, lr_b, sd_b, busy_b, ur_b;
  logic [15:0] sl_b, sr_b;

  i2s_tx #(.WIDTH(32)) u_a (
    .sclk(sclk), .rst(rst), .en(en_a),
    .s_valid(sv_a), .s_ready(rdy_a),
    .s_left(sl_a), .s_right(sr_a),
    .lrclk(lr_a), .sdata(sd_a),
    .busy(busy_a), .underrun(ur_a)
  );

  i2s_tx #(.WIDTH(16)) u_b (
    .sclk(sclk), .rst(rst), .en(en_b),
    .s_valid(sv_b), .s_ready(rdy_b),
    .s_left(sl_b), .s_right(sr_b),
    .lrclk(lr_b), .sdata(sd_b),
    .busy(busy_b), .underrun(ur_b)
  );

  bit   sel16;
  logic m_lr, m_sd, m_busy, m_ur, m_rdy, m_sv;
  assign m_lr   = sel16 ? lr_b   : lr_a;
  assign m_sd   = sel16 ? sd_b   : sd_a;
  assign m_busy = sel16 ? busy_b : busy_a;
  assign m_ur   = sel16 ? ur_b   : ur_a;
  assign m_rdy  = sel16 ? rdy_b  : rdy_a;
  assign m_sv   = sel16 ? sv_b   : sv_a;

  int n_chk;
  int n_fail;

  bit          stream_on;
  logic [31:0] st_l [4];
  logic [31:0] st_r [4];
  int          st_idx;
  bit          acc_flag;
  int          acc_cnt;

  task automatic drive(input logic v, input logic [31:0] l,
                       input logic [31:0] r);
    if (sel16) begin
      sv_b = v; sl_b = l[15:0]; sr_b = r[15:0];
    end else begin
      sv_a = v; sl_a = l; sr_a = r;
    end
  endtask

  task automatic set_en(input logic v);
    if (sel16) en_b = v;
    else en_a = v;
  endtask

  task automatic preload(input logic [31:0] l, input logic [31:0] r);
    drive(1'b1, l, r);
    @(negedge sclk);
    n_chk++;
    if (m_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL preload_ready: got %b want 0", m_rdy);
    end
    drive(1'b0, l, r);
  endtask

  // Reference: frame starting at cycle 1 carries pair bits MSB-first,
  // one bit per cycle; the last bit falls in cycle 0 of the next frame.
  task automatic run_frame(input logic [63:0] pair, input bit ur,
                           input int rmode, input int off,
                           input int last);
    int w;
    int fl;
    w  = sel16 ? 16 : 32;
    fl = 2 * w;
    for (int k = 1; k <= last; k++) begin
      int   c;
      logic e_sd, e_lr, e_ur, e_rdy;
      c     = k % fl;
      e_sd  = pair[fl-k];
      e_lr  = (c >= w);
      e_ur  = ur && (k == 1);
      e_rdy = (rmode == 1) ? (k == 1) : 1'b1;
      n_chk++;
      if (m_sd !== e_sd) begin
        n_fail++;
        $display("FAIL sdata k=%0d: got %b want %b", k, m_sd, e_sd);
      end
      n_chk++;
      if (m_lr !== e_lr) begin
        n_fail++;
        $display("FAIL lrclk k=%0d: got %b want %b", k, m_lr, e_lr);
      end
      n_chk++;
      if (m_ur !== e_ur) begin
        n_fail++;
        $display("FAIL underrun k=%0d: got %b want %b", k, m_ur, e_ur);
      end
      n_chk++;
      if (m_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy k=%0d: got %b want 1", k, m_busy);
      end
      if (rmode != 0) begin
        n_chk++;
        if (m_rdy !== e_rdy) begin
          n_fail++;
          $display("FAIL s_ready k=%0d: got %b want %b", k, m_rdy, e_rdy);
        end
      end
      if (stream_on) begin
        if (acc_flag) begin
          acc_flag = 1'b0;
          st_idx++;
          if (st_idx < 4) drive(1'b1, st_l[st_idx], st_r[st_idx]);
          else drive(1'b0, '0, '0);
        end
        if (m_sv && m_rdy) begin
          acc_flag = 1'b1;
          acc_cnt++;
        end
      end
      if (k == off) set_en(1'b0);
      @(negedge sclk);
    end
    if (off > 0) begin
      n_chk++;
      if (m_busy !== 1'b0 || m_sd !== 1'b0 || m_lr !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after: got busy=%b sdata=%b lrclk=%b want 0 0 0",
                 m_busy, m_sd, m_lr);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en_a = 0; sv_a = 0; sl_a = '0; sr_a = '0;
    en_b = 0; sv_b = 0; sl_b = '0; sr_b = '0;
    sel16 = 0; stream_on = 0;
    repeat (2) @(negedge sclk);
    n_chk++;
    if ({lr_a, sd_a, busy_a, ur_a, rdy_a} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_a: got %b want 00001",
               {lr_a, sd_a, busy_a, ur_a, rdy_a});
    end
    n_chk++;
    if ({lr_b, sd_b, busy_b, ur_b, rdy_b} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_b: got %b want 00001",
               {lr_b, sd_b, busy_b, ur_b, rdy_b});
    end
    rst = 1'b0;
    @(negedge sclk);
    n_chk++;
    if (busy_a !== 1'b0 || rdy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%b rdy=%b want 0 1",
               busy_a, rdy_a);
    end
  endtask

  task automatic test_zero_frame();
    set_en(1'b1);
    @(negedge sclk);
    run_frame(64'h0, 1'b1, 2, 10, 64);
  endtask

  task automatic test_preload();
    preload(32'hA5A5_0001, 32'h8000_00FF);
    set_en(1'b1);
    @(negedge sclk);
    run_frame({32'hA5A5_0001, 32'h8000_00FF}, 1'b0, 2, 5, 64);
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] l, r;
      l = $urandom;
      r = $urandom;
      preload(l, r);
      set_en(1'b1);
      @(negedge sclk);
      run_frame({l, r}, 1'b0, 2, 3 + i * 20, 64);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      st_l[i] = $urandom;
      st_r[i] = $urandom;
    end
    acc_flag = 1'b0;
    st_idx   = 0;
    drive(1'b1, st_l[0], st_r[0]);
    @(negedge sclk);
    st_idx = 1;
    drive(1'b1, st_l[1], st_r[1]);
    set_en(1'b1);
    stream_on = 1'b1;
    @(negedge sclk);
    for (int f = 0; f < 4; f++) begin
      acc_cnt = 0;
      run_frame({st_l[f], st_r[f]}, 1'b0, (f < 3) ? 1 : 2,
                (f == 3) ? 5 : 0, 64);
      n_chk++;
      if (acc_cnt !== ((f < 3) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL accepts_frame%0d: got %0d want %0d",
                 f, acc_cnt, (f < 3) ? 1 : 0);
      end
    end
    stream_on = 1'b0;
  endtask

  task automatic test_en_drop();
    logic [31:0] l, r;
    l = $urandom;
    r = $urandom | 32'h1;
    preload(l, r);
    set_en(1'b1);
    @(negedge sclk);
    run_frame({l, r}, 1'b0, 2, 40, 64);
  endtask

  task automatic test_reset_mid();
    logic [31:0] l3, r3;
    preload(32'hFFFF_FFFF, 32'h0F0F_0F0F);
    set_en(1'b1);
    @(negedge sclk);
    run_frame({32'hFFFF_FFFF, 32'h0F0F_0F0F}, 1'b0, 2, 0, 1);
    drive(1'b1, 32'h1357_9BDF, 32'h2468_ACE0);
    @(negedge sclk);
    drive(1'b0, '0, '0);
    n_chk++;
    if (m_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_full: got s_ready=%b want 0", m_rdy);
    end
    repeat (17) @(negedge sclk);
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({m_lr, m_sd, m_busy, m_ur, m_rdy} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_mid: got %b want 00001",
               {m_lr, m_sd, m_busy, m_ur, m_rdy});
    end
    set_en(1'b0);
    @(negedge sclk);
    rst = 1'b0;
    l3 = $urandom;
    r3 = $urandom;
    preload(l3, r3);
    set_en(1'b1);
    @(negedge sclk);
    run_frame({l3, r3}, 1'b0, 2, 7, 64);
  endtask

  task automatic test_width16();
    logic [31:0] l, r;
    sel16 = 1'b1;
    @(negedge sclk);
    preload(32'h1234, 32'hFEDC);
    set_en(1'b1);
    @(negedge sclk);
    run_frame({32'h0, 16'h1234, 16'hFEDC}, 1'b0, 2, 5, 32);
    l = {16'h0, 16'($urandom)};
    r = {16'h0, 16'($urandom)};
    preload(l, r);
    set_en(1'b1);
    @(negedge sclk);
    run_frame({32'h0, l[15:0], r[15:0]}, 1'b0, 2, 20, 32);
    sel16 = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_zero_frame();
    test_preload();
    test_random_frames();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_width16();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
